control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Reads the 4-bit opcode held by the instruction register and sequences the CPU.
//  Steps through a T-state ring, T1..T6, and drives the one-hot control strobes for
//  PC, MAR, RAM, IR, A, B, ALU and OUT, including the IR's own load strobe.
//  Datapath registers sample on negedge clk; this block advances on posedge clk,
//  so every strobe is stable for a full half-cycle before it is used.
// PARAMETERS
//  OPCODE_W  4  opcode width (bus[15:12] as captured by the IR)
//  NUM_T     6  T-states per instruction (fetch T1-T3, execute T4-T6)
// PORTS
//  clk        in   1         system clock; state advances on posedge
//  rst_n      in   1         asynchronous active-low reset
//  run        in   1         1 = advance; 0 = freeze state, all strobes 0
//  opcode     in   OPCODE_W  IR output; valid from negedge of T3 onward
//  zero_flag  in   1         ALU zero flag (registered), sampled in T4 of JZ
//  tstate     out  NUM_T     one-hot current T-state (bit0 = T1)
//  pc_out     out  1         PC drives bus
//  pc_inc     out  1         PC increments
//  pc_load    out  1         PC loads from bus
//  mar_load   out  1         MAR loads from bus
//  mem_out    out  1         RAM drives bus
//  mem_we     out  1         RAM writes from bus
//  ir_load    out  1         IR loads bus[15:12]
//  ir_oe      out  1         IR operand field drives bus
//  a_load     out  1         A register loads
//  a_out      out  1         A register drives bus
//  b_load     out  1         B register loads
//  alu_out    out  1         ALU drives bus
//  alu_sub    out  1         ALU subtracts (else adds)
//  out_load   out  1         output register loads
//  halted     out  1         sticky halt indicator
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=T1 and halted=0; all strobes forced 0 while in reset.
//    The first posedge after release executes T1. Reset mid-instruction aborts the
//    instruction and does not complete its T-states.
//  - Strobes: combinational from registered state and opcode; glitch-free at negedges.
//  - Fetch (all opcodes): T1 pc_out+mar_load; T2 pc_inc; T3 mem_out+ir_load.
//  - Execute:
//    LDA 0000: T4 ir_oe+mar_load; T5 mem_out+a_load.
//    ADD 0001: T4 ir_oe+mar_load; T5 mem_out+b_load; T6 alu_out+a_load.
//    SUB 0010: as ADD, with alu_sub=1 in T6.
//    STA 0011: T4 ir_oe+mar_load; T5 a_out+mem_we.
//    JMP 0100: T4 ir_oe+pc_load.
//    JZ  0101: T4 ir_oe+pc_load only if zero_flag=1; otherwise no strobes.
//    OUT 1110: T4 a_out+out_load.
//    HLT 1111: T4 no strobes; next posedge enters HALT.
//    Undefined opcodes: NOP, with no execute strobes.
//  - Ring: T6 -> T1. In HALT: tstate=0, halted=1, all strobes 0, run ignored; left only
//    by reset.
//  - run=0: state holds and all strobes are 0. On return to 1 the held T-state re-issues
//    its strobes. An instruction never splits across a run gap.
// CONFIGURATION
//  CTRL_EARLY_END_EN defined: after an opcode's last active T-state, the next state is
//    T1. Last active states: LDA/STA T5, JMP/JZ/OUT T4, NOP T4, ADD/SUB T6.
//  Undefined: every instruction occupies all six T-states, with idle states issuing no strobes.
// STRUCTURE
//  - Shared header ctrl_defs.vh: opcode localparams (OP_LDA..OP_HLT), T-state one-hot
//    constants, and control-word bit indices, also used by the top and the bench.
//  - One sub-module, ctrl_decoder: purely combinational (opcode, tstate, zero_flag) ->
//    control word. This module holds the ring/HALT register and the output gating.
// TESTING
//  1. Reset then LDA fetch: opcode=0000, run=1 -> T1 pc_out+mar_load, T2 pc_inc,
//     T3 mem_out+ir_load, T4 ir_oe+mar_load, T5 mem_out+a_load, T6 no strobes.
//  2. ADD vs SUB: opcode 0001 then 0010 -> T6 shows alu_out+a_load, with alu_sub=0
//     then alu_sub=1.
//  3. JZ: zero_flag=0 -> T4 has no strobes; zero_flag=1 -> T4 ir_oe+pc_load.
//  4. HLT 1111: T4 no strobes; then halted=1 and tstate=0. Toggling run for 10 cycles
//     changes nothing; rst_n pulse -> T1, halted=0.
//  5. Async reset asserted mid-T5 of ADD, off the clock edge -> strobes drop to 0
//     immediately; after release the next posedge issues T1.
//  6. CTRL_EARLY_END_EN build: OUT 1110 -> tstate sequence T1,T2,T3,T4,T1 (5 clocks);
//     without the macro -> T1..T6,T1 (7 clocks).

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, T-state one-hot codes,
// control-word bit positions and the sequencer state type.
package control_sequencer_pkg;

  localparam int OPCODE_W = 4;
  localparam int NUM_T    = 6;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  localparam logic [NUM_T-1:0] T1_OH = 6'b000001;
  localparam logic [NUM_T-1:0] T2_OH = 6'b000010;
  localparam logic [NUM_T-1:0] T3_OH = 6'b000100;
  localparam logic [NUM_T-1:0] T4_OH = 6'b001000;
  localparam logic [NUM_T-1:0] T5_OH = 6'b010000;
  localparam logic [NUM_T-1:0] T6_OH = 6'b100000;

  localparam int CW_PC_OUT   = 0;
  localparam int CW_PC_INC   = 1;
  localparam int CW_PC_LOAD  = 2;
  localparam int CW_MAR_LOAD = 3;
  localparam int CW_MEM_OUT  = 4;
  localparam int CW_MEM_WE   = 5;
  localparam int CW_IR_LOAD  = 6;
  localparam int CW_IR_OE    = 7;
  localparam int CW_A_LOAD   = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_LOAD   = 10;
  localparam int CW_ALU_OUT  = 11;
  localparam int CW_ALU_SUB  = 12;
  localparam int CW_OUT_LOAD = 13;
  localparam int CW_W        = 14;

  typedef logic [CW_W-1:0] ctrl_word_t;

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } seq_state_t;

  // Final T-state that carries strobes for each opcode; used to shorten the ring.
  function automatic seq_state_t last_state(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LDA, OP_STA: return S_T5;
      OP_ADD, OP_SUB: return S_T6;
      default:        return S_T4;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (slave side) and the CPU datapath (master side).
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                zero_flag;
  logic [NUM_T-1:0]    tstate;
  logic                pc_out;
  logic                pc_inc;
  logic                pc_load;
  logic                mar_load;
  logic                mem_out;
  logic                mem_we;
  logic                ir_load;
  logic                ir_oe;
  logic                a_load;
  logic                a_out;
  logic                b_load;
  logic                alu_out;
  logic                alu_sub;
  logic                out_load;
  logic                halted;

  modport slave (
    input  run, opcode, zero_flag,
    output tstate, pc_out, pc_inc, pc_load, mar_load, mem_out, mem_we, ir_load, ir_oe,
           a_load, a_out, b_load, alu_out, alu_sub, out_load, halted
  );

  modport master (
    output run, opcode, zero_flag,
    input  tstate, pc_out, pc_inc, pc_load, mar_load, mem_out, mem_we, ir_load, ir_oe,
           a_load, a_out, b_load, alu_out, alu_sub, out_load, halted
  );

endinterface

// File: rtl/control_sequencer_decoder.sv
// Purely combinational microcode table: (opcode, one-hot T-state, zero flag) -> control word.
module ctrl_decoder
  import control_sequencer_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [NUM_T-1:0]    tstate,
  input  logic                zero_flag,
  output ctrl_word_t          cw
);

  always_comb begin
    cw = '0;
    // Fetch is identical for every opcode.
    if (tstate[0]) begin
      cw[CW_PC_OUT]   = 1'b1;
      cw[CW_MAR_LOAD] = 1'b1;
    end
    if (tstate[1]) cw[CW_PC_INC] = 1'b1;
    if (tstate[2]) begin
      cw[CW_MEM_OUT] = 1'b1;
      cw[CW_IR_LOAD] = 1'b1;
    end

    case (opcode)
      OP_LDA: begin
        if (tstate[3]) begin
          cw[CW_IR_OE]    = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        if (tstate[4]) begin
          cw[CW_MEM_OUT] = 1'b1;
          cw[CW_A_LOAD]  = 1'b1;
        end
      end
      OP_ADD, OP_SUB: begin
        if (tstate[3]) begin
          cw[CW_IR_OE]    = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        if (tstate[4]) begin
          cw[CW_MEM_OUT] = 1'b1;
          cw[CW_B_LOAD]  = 1'b1;
        end
        if (tstate[5]) begin
          cw[CW_ALU_OUT] = 1'b1;
          cw[CW_A_LOAD]  = 1'b1;
          cw[CW_ALU_SUB] = (opcode == OP_SUB);
        end
      end
      OP_STA: begin
        if (tstate[3]) begin
          cw[CW_IR_OE]    = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        if (tstate[4]) begin
          cw[CW_A_OUT]  = 1'b1;
          cw[CW_MEM_WE] = 1'b1;
        end
      end
      OP_JMP: begin
        if (tstate[3]) begin
          cw[CW_IR_OE]   = 1'b1;
          cw[CW_PC_LOAD] = 1'b1;
        end
      end
      OP_JZ: begin
        if (tstate[3] && zero_flag) begin
          cw[CW_IR_OE]   = 1'b1;
          cw[CW_PC_LOAD] = 1'b1;
        end
      end
      OP_OUT: begin
        if (tstate[3]) begin
          cw[CW_A_OUT]    = 1'b1;
          cw[CW_OUT_LOAD] = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// CPU control sequencer: T1..T6 ring plus sticky HALT, with gated one-hot strobes.
// Define CTRL_EARLY_END_EN to return to T1 right after each opcode's last active T-state.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.slave  bus
);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic [NUM_T-1:0] tstate;
  ctrl_word_t       cw;
  ctrl_word_t       cw_gated;
  logic             active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_T1;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.run && state_reg != S_HALT) begin
      if (state_reg == S_T4 && bus.opcode == OP_HLT) begin
        state_next = S_HALT;
`ifdef CTRL_EARLY_END_EN
      end else if (state_reg == last_state(bus.opcode)) begin
        state_next = S_T1;
`endif
      end else begin
        case (state_reg)
          S_T1:    state_next = S_T2;
          S_T2:    state_next = S_T3;
          S_T3:    state_next = S_T4;
          S_T4:    state_next = S_T5;
          S_T5:    state_next = S_T6;
          default: state_next = S_T1;
        endcase
      end
    end
  end

  always_comb begin
    case (state_reg)
      S_T1:    tstate = T1_OH;
      S_T2:    tstate = T2_OH;
      S_T3:    tstate = T3_OH;
      S_T4:    tstate = T4_OH;
      S_T5:    tstate = T5_OH;
      S_T6:    tstate = T6_OH;
      default: tstate = '0;
    endcase
  end

  ctrl_decoder u_decoder (
    .opcode    (bus.opcode),
    .tstate    (tstate),
    .zero_flag (bus.zero_flag),
    .cw        (cw)
  );

  // rst_n is folded in combinationally so strobes drop the instant reset asserts.
  assign active   = rst_n && bus.run && (state_reg != S_HALT);
  assign cw_gated = active ? cw : '0;

  assign bus.tstate   = tstate;
  assign bus.halted   = (state_reg == S_HALT);
  assign bus.pc_out   = cw_gated[CW_PC_OUT];
  assign bus.pc_inc   = cw_gated[CW_PC_INC];
  assign bus.pc_load  = cw_gated[CW_PC_LOAD];
  assign bus.mar_load = cw_gated[CW_MAR_LOAD];
  assign bus.mem_out  = cw_gated[CW_MEM_OUT];
  assign bus.mem_we   = cw_gated[CW_MEM_WE];
  assign bus.ir_load  = cw_gated[CW_IR_LOAD];
  assign bus.ir_oe    = cw_gated[CW_IR_OE];
  assign bus.a_load   = cw_gated[CW_A_LOAD];
  assign bus.a_out    = cw_gated[CW_A_OUT];
  assign bus.b_load   = cw_gated[CW_B_LOAD];
  assign bus.alu_out  = cw_gated[CW_ALU_OUT];
  assign bus.alu_sub  = cw_gated[CW_ALU_SUB];
  assign bus.out_load = cw_gated[CW_OUT_LOAD];

endmodule
